// File: rtl/prf_pkg.sv
// Shared types and constants for the physical register file write-back path.
// Contents:
//   PR_IDX_W, DATA_W, NUM_PR, ENTRY_W   widths and register count
//   pr_idx_t, pr_value_t                 index / value types
//   wb_entry_t                           one buffered write-back result {idx, value}
//   idx_legal()                          true when an index names a real physical register
package prf_pkg;

    localparam int PR_IDX_W = 7;
    localparam int DATA_W   = 64;
    localparam int NUM_PR   = 96;
    localparam int ENTRY_W  = PR_IDX_W + DATA_W;

    typedef logic [PR_IDX_W-1:0] pr_idx_t;
    typedef logic [DATA_W-1:0]   pr_value_t;

    typedef struct packed {
        pr_idx_t   idx;
        pr_value_t value;
    } wb_entry_t;

    function automatic logic idx_legal(input pr_idx_t idx, input int num_pr);
        return int'(idx) < num_pr;
    endfunction

endpackage

// File: rtl/wb_src_fifo.sv
// Per-source result FIFO for the write-back arbiter.
// Ports:
//   clock        posedge clock
//   reset        asynchronous, active-low
//   push         write push_entry (ignored when full)
//   push_entry   packed wb_entry_t
//   pop          drop the head entry (ignored when empty)
//   count        registered occupancy, 0..DEPTH
//   head         oldest entry (undefined when count==0)
// DEPTH must be a power of two so the pointers wrap naturally.
module wb_src_fifo
    import prf_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               push,
    input  logic [ENTRY_W-1:0] push_entry,
    input  logic               pop,
    output logic [CNT_W-1:0]   count,
    output logic [ENTRY_W-1:0] head
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic               do_push, do_pop;

    always_comb begin
        do_push  = push && (int'(count_q) < DEPTH);
        do_pop   = pop && (count_q != '0);
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; occupancy alone decides what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem_q[wr_ptr_q] <= push_entry;
    end

    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/prf_wb_arbiter.sv
// Write side of the physical register file: buffers results from the sim/mul/mem units in
// per-source FIFOs and round-robin grants up to NUM_WR of them per cycle onto registered PRF
// write ports, which also serve as the wakeup tag broadcast.
// Ports:
//   clock, reset                 posedge clock, asynchronous active-low reset
//   src_valid/src_ready          per-source handshake (ready from registered occupancy only)
//   src_pr_idx, src_value        per-source result, source s at [s*W +: W]
//   wr_enable/wr_pr_idx/wr_value registered PRF write ports; port 1 used only with port 0
//   err_bad_idx                  sticky: a source offered idx >= NUM_PR (entry dropped)
//   err_dup_idx                  sticky: two ports wrote the same idx in one cycle
// Build option: define PRF_WB_BYPASS_EN to let a result arriving at an empty FIFO compete for
// a port in the same cycle (1-edge latency). Without it every result goes through its FIFO.
module prf_wb_arbiter #(
    parameter int NUM_SRC    = 3,
    parameter int NUM_WR     = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int PR_IDX_W   = prf_pkg::PR_IDX_W,
    parameter int DATA_W     = prf_pkg::DATA_W,
    parameter int NUM_PR     = prf_pkg::NUM_PR
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_SRC-1:0]           src_valid,
    output logic [NUM_SRC-1:0]           src_ready,
    input  logic [NUM_SRC*PR_IDX_W-1:0]  src_pr_idx,
    input  logic [NUM_SRC*DATA_W-1:0]    src_value,
    output logic [NUM_WR-1:0]            wr_enable,
    output logic [NUM_WR*PR_IDX_W-1:0]   wr_pr_idx,
    output logic [NUM_WR*DATA_W-1:0]     wr_value,
    output logic                         err_bad_idx,
    output logic                         err_dup_idx
);

    import prf_pkg::*;

    localparam int RR_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_entry_t          src_entry  [NUM_SRC];
    wb_entry_t          fifo_head  [NUM_SRC];
    logic [CNT_W-1:0]   fifo_count [NUM_SRC];
    logic [NUM_SRC-1:0] fifo_empty, src_good, src_acc, push, pop, byp_take;

    logic               ready_q, ready_d;
    logic [RR_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_WR-1:0]  wr_en_q, wr_en_d;
    wb_entry_t          wr_entry_q [NUM_WR];
    wb_entry_t          wr_entry_d [NUM_WR];
    logic               err_bad_q, err_bad_d, err_dup_q, err_dup_d;

    int                 s, grant_n, last_src;
    logic               cand_vld, cand_fifo, dup_hit;
    wb_entry_t          cand_entry;

    // ---------------- source intake ----------------
    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign src_entry[g].idx   = src_pr_idx[g*PR_IDX_W +: PR_IDX_W];
        assign src_entry[g].value = src_value[g*DATA_W +: DATA_W];
        // ready_q keeps every source closed while reset is held
        assign src_ready[g]  = ready_q && (int'(fifo_count[g]) < FIFO_DEPTH);
        assign src_good[g]   = idx_legal(src_entry[g].idx, NUM_PR);
        assign src_acc[g]    = src_valid[g] && src_ready[g];
        assign push[g]       = src_acc[g] && src_good[g] && !byp_take[g];
        assign fifo_empty[g] = (fifo_count[g] == '0);

        wb_src_fifo #(
            .DEPTH (FIFO_DEPTH),
            .CNT_W (CNT_W)
        ) u_fifo (
            .clock      (clock),
            .reset      (reset),
            .push       (push[g]),
            .push_entry (src_entry[g]),
            .pop        (pop[g]),
            .count      (fifo_count[g]),
            .head       (fifo_head[g])
        );
    end

    // ---------------- round-robin grant ----------------
    always_comb begin
        grant_n    = 0;
        last_src   = 0;
        s          = 0;
        cand_vld   = 1'b0;
        cand_fifo  = 1'b0;
        cand_entry = '0;
        pop        = '0;
        byp_take   = '0;
        wr_en_d    = '0;
        for (int p = 0; p < NUM_WR; p++) wr_entry_d[p] = '0;

        for (int k = 0; k < NUM_SRC; k++) begin
            s          = (int'(rr_ptr_q) + k) % NUM_SRC;
            cand_vld   = 1'b0;
            cand_fifo  = 1'b0;
            cand_entry = '0;
            for (int j = 0; j < NUM_SRC; j++) begin
                if (j == s) begin
                    if (!fifo_empty[j]) begin
                        cand_vld   = 1'b1;
                        cand_fifo  = 1'b1;
                        cand_entry = fifo_head[j];
                    end
`ifdef PRF_WB_BYPASS_EN
                    // An empty FIFO means the incoming result is the oldest for this source.
                    else if (src_acc[j] && src_good[j]) begin
                        cand_vld   = 1'b1;
                        cand_entry = src_entry[j];
                    end
`endif
                end
            end
            if (cand_vld && grant_n < NUM_WR) begin
                for (int j = 0; j < NUM_SRC; j++) begin
                    if (j == s) begin
                        if (cand_fifo) pop[j] = 1'b1;
                        else           byp_take[j] = 1'b1;
                    end
                end
                for (int p = 0; p < NUM_WR; p++) begin
                    if (p == grant_n) begin
                        wr_en_d[p]    = 1'b1;
                        wr_entry_d[p] = cand_entry;
                    end
                end
                grant_n  = grant_n + 1;
                last_src = s;
            end
        end

        rr_ptr_d = rr_ptr_q;
        if (grant_n != 0) rr_ptr_d = RR_W'((last_src + 1) % NUM_SRC);

        dup_hit = 1'b0;
        for (int a = 0; a < NUM_WR; a++) begin
            for (int b = a + 1; b < NUM_WR; b++) begin
                if (wr_en_d[a] && wr_en_d[b] && (wr_entry_d[a].idx == wr_entry_d[b].idx))
                    dup_hit = 1'b1;
            end
        end

        ready_d   = 1'b1;
        err_bad_d = err_bad_q || (|(src_acc & ~src_good));
        err_dup_d = err_dup_q || dup_hit;
    end

    // ---------------- output / state registers ----------------
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ready_q   <= 1'b0;
            rr_ptr_q  <= '0;
            wr_en_q   <= '0;
            for (int p = 0; p < NUM_WR; p++) wr_entry_q[p] <= '0;
            err_bad_q <= 1'b0;
            err_dup_q <= 1'b0;
        end else begin
            ready_q   <= ready_d;
            rr_ptr_q  <= rr_ptr_d;
            wr_en_q   <= wr_en_d;
            for (int p = 0; p < NUM_WR; p++) wr_entry_q[p] <= wr_entry_d[p];
            err_bad_q <= err_bad_d;
            err_dup_q <= err_dup_d;
        end
    end

    for (genvar p = 0; p < NUM_WR; p++) begin : g_port
        assign wr_pr_idx[p*PR_IDX_W +: PR_IDX_W] = wr_entry_q[p].idx;
        assign wr_value[p*DATA_W +: DATA_W]      = wr_entry_q[p].value;
    end

    assign wr_enable   = wr_en_q;
    assign err_bad_idx = err_bad_q;
    assign err_dup_idx = err_dup_q;

endmodule
